telem_channel_sched: RTL
========================

Name: telem_channel_sched

Overview:
Controller for the four-channel discrete telemetry storage. Generates the rotating one-hot phase strobes that time each channel slot and arbitrates per-channel sample requests round-robin. For the granted channel it issues a load or zero-write in that channel's phase slot, waits out the storage delay-line latency, then presents the stored bit to the telemetry consumer with a valid/ready handshake.

Parameters:
DL_DELAY, 8, TICKs from LOAD until the stored bit is readable; legal range 1..255 (8-bit counter).
TIMEOUT, 16, TICKs allowed in PRESENT before the sample is dropped; used only with TELEM_TIMEOUT_EN; legal range 1..255.

Ports:
SIM_CLK  in  1  system clock; all state changes on its rising edge.
SIM_RST  in  1  reset; synchronous, active-high.
TICK  in  1  bit-time enable; the phase counter and delay counter advance only when TICK=1.
REQ  in  4  per-channel sample request (level); bit0=channel 1.
DC_IN  in  4  discrete channel input levels.
ZERO_REQ  in  1  when sampled at LOAD, the slot is a zero-write instead of a sample.
OUT_RDY  in  1  consumer ready.
PH  out  4  one-hot phase strobe; PH[k]=1 while phase==k.
SEL  out  2  channel currently granted.
LOAD  out  1  one-clock storage load pulse.
ZERW  out  1  zero-write qualifier; only ever high together with LOAD.
BUSY  out  1  high in every state except IDLE.
OUT_VLD  out  1  stored bit valid.
OUT_CH  out  2  channel of the presented bit.
OUT_BIT  out  1  presented bit.
ACK  out  4  one-hot, one-clock service-complete pulse.
ERR  out  1  sticky timeout flag; exists only with TELEM_TIMEOUT_EN.

Behaviour:
- Reset (SIM_RST=1 at a clock edge): phase=0 (PH=4'b0001), state=IDLE, round-robin pointer=3, SEL=0, LOAD=0, ZERW=0, BUSY=0, OUT_VLD=0, OUT_CH=0, OUT_BIT=0, ACK=0, delay counter=0, ERR=0.
- Reset mid-operation: the operation is abandoned, no ACK is issued, and all state returns to the reset values above.
- Phase: 2-bit counter, increments modulo 4 on each clock with TICK=1, independent of the FSM.
- FSM states: IDLE, ARB, ALIGN, LOAD, DELAY, PRESENT.
- IDLE: if REQ!=0, go to ARB; otherwise stay in IDLE.
- ARB (1 clock):
  - Grant the first set REQ bit searching from pointer+1 upward, wrapping modulo 4.
  - Register the grant into SEL, go to ALIGN.
  - If REQ has dropped to 0 by this clock, return to IDLE with no grant.
- ALIGN: go to LOAD at the first clock edge where phase==SEL and TICK=1.
- LOAD (exactly 1 clock):
  - LOAD=1, ZERW=ZERO_REQ.
  - Capture data = ZERO_REQ ? 0 : DC_IN[SEL].
  - Load the delay counter with DL_DELAY; go to DELAY.
- DELAY: decrement the counter on each TICK; go to PRESENT on the clock where it reaches 0. Latency from LOAD to OUT_VLD is exactly DL_DELAY TICKs.
- PRESENT:
  - OUT_VLD=1, OUT_CH=SEL, OUT_BIT=captured data; all three held stable until the handshake.
  - On a clock with OUT_VLD&OUT_RDY: ACK[SEL]=1 in the next clock, pointer=SEL, state=IDLE.
- Withdrawn request: REQ dropping after ARB does not abort the operation; the service completes and is ACKed.
- Re-request: a REQ still held after its ACK is re-arbitrated. With all four REQs held, service order is 1,2,3,4,1,...
- Simultaneous events: ZERO_REQ, DC_IN and REQ are sampled only in the states named above; changes at other times have no effect.
- The FSM never returns to IDLE without passing through the ACK, reset or timeout paths.

Optional Feature:
Macro TELEM_TIMEOUT_EN.
- Defined:
  - The PRESENT TICK count is compared against TIMEOUT.
  - On reaching TIMEOUT with no handshake: OUT_VLD drops, ACK[SEL] pulses, pointer=SEL, state=IDLE, ERR is set.
  - ERR stays set until SIM_RST.
  - A handshake on the same clock as the timeout takes priority: normal completion, ERR unchanged.
- Undefined: the ERR port is absent and PRESENT waits indefinitely for OUT_RDY.

Test Plan:
- Reset: assert SIM_RST 2 clocks with TICK=1 and all REQ=1 -> PH=0001, all other outputs 0, BUSY=0; the first grant after release is channel 1 (SEL=0).
- Single request: REQ=0100, DC_IN=0100, TICK=1, DL_DELAY=8, OUT_RDY=1 -> LOAD only in a clock with PH=0100; OUT_VLD exactly 8 TICKs after LOAD with OUT_CH=2, OUT_BIT=1; then ACK=0100 for 1 clock.
- Round-robin: REQ=1111 held -> ACK order 0001, 0010, 0100, 1000, 0001.
- Zero-write: REQ=0001, ZERO_REQ=1, DC_IN=1111 -> LOAD=ZERW=1 in the same clock; OUT_BIT=0.
- Backpressure and reset: OUT_RDY=0 for 20 TICKs -> OUT_VLD, OUT_CH and OUT_BIT stable with no ACK; assert SIM_RST during DELAY -> no ACK, IDLE next clock.
- Timeout (TELEM_TIMEOUT_EN, TIMEOUT=16): OUT_RDY=0 -> OUT_VLD drops after 16 TICKs, ACK pulses once, ERR=1 and stays 1 until SIM_RST.

Source files
------------

// File: rtl/telem_channel_sched.sv
// Four-channel telemetry slot scheduler: one-hot phase strobes, round-robin grant,
// phase-aligned load, delay-line wait and valid/ready presentation.
// Optional macro TELEM_TIMEOUT_EN adds a PRESENT timeout with a sticky ERR flag.
module telem_channel_sched #(
    parameter int unsigned DL_DELAY = 8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       TICK,
    input  logic [3:0] REQ,
    input  logic [3:0] DC_IN,
    input  logic       ZERO_REQ,
    input  logic       OUT_RDY,
    output logic [3:0] PH,
    output logic [1:0] SEL,
    output logic       LOAD,
    output logic       ZERW,
    output logic       BUSY,
    output logic       OUT_VLD,
    output logic [1:0] OUT_CH,
    output logic       OUT_BIT,
`ifdef TELEM_TIMEOUT_EN
    output logic [3:0] ACK,
    output logic       ERR
`else
    output logic [3:0] ACK
`endif
);

    if (DL_DELAY < 1 || DL_DELAY > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("telem_channel_sched: DL_DELAY and TIMEOUT must lie in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_ALIGN, S_LOAD, S_DELAY, S_PRESENT
    } state_t;

    localparam logic [7:0] DL8 = 8'(DL_DELAY);

    state_t     state_q;
    logic [3:0] ph_q, ph_d;
    logic [1:0] ptr_q, sel_q, och_q, grant_d;
    logic       grant_vld_d;
    logic [7:0] cnt_q, cnt_load_d;
    logic       data_q, load_q, zerw_q, busy_q, vld_q, obit_q;
    logic [3:0] ack_q;
    logic [1:0] cand_s;
`ifdef TELEM_TIMEOUT_EN
    localparam logic [7:0] TO8 = 8'(TIMEOUT);
    logic [7:0] tcnt_q;
    logic       err_q;
    assign ERR = err_q;
`endif

    // Next phase, round-robin grant from pointer+1, and delay preload (the LOAD clock's TICK counts).
    always_comb begin
        ph_d        = TICK ? {ph_q[2:0], ph_q[3]} : ph_q;
        grant_d     = 2'd0;
        grant_vld_d = 1'b0;
        cand_s      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand_s = ptr_q + 2'(k);
            if (!grant_vld_d && REQ[cand_s]) begin
                grant_d     = cand_s;
                grant_vld_d = 1'b1;
            end
        end
        cnt_load_d = TICK ? (DL8 - 8'd1) : DL8;
    end

    // Free-running one-hot phase strobe.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) ph_q <= 4'b0001;
        else         ph_q <= ph_d;
    end

    // Slot FSM with registered outputs.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            cnt_q   <= 8'd0;
            data_q  <= 1'b0;
            load_q  <= 1'b0;
            zerw_q  <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            och_q   <= 2'd0;
            obit_q  <= 1'b0;
            ack_q   <= 4'b0000;
`ifdef TELEM_TIMEOUT_EN
            tcnt_q  <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            load_q <= 1'b0;
            zerw_q <= 1'b0;
            ack_q  <= 4'b0000;
            case (state_q)
                S_IDLE: begin
                    if (REQ != 4'b0000) begin
                        state_q <= S_ARB;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (grant_vld_d) begin
                        sel_q   <= grant_d;
                        state_q <= S_ALIGN;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    // Enter LOAD on the edge the phase steps into the granted slot.
                    if (TICK && ph_d[sel_q]) begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        zerw_q  <= ZERO_REQ;
                        data_q  <= ~ZERO_REQ & DC_IN[sel_q];
                    end
                end
                S_LOAD: begin
                    cnt_q <= cnt_load_d;
                    if (cnt_load_d == 8'd0) begin
                        state_q <= S_PRESENT;
                        vld_q   <= 1'b1;
                        och_q   <= sel_q;
                        obit_q  <= data_q;
`ifdef TELEM_TIMEOUT_EN
                        tcnt_q  <= 8'd0;
`endif
                    end else begin
                        state_q <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (TICK) begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_q <= S_PRESENT;
                            vld_q   <= 1'b1;
                            och_q   <= sel_q;
                            obit_q  <= data_q;
`ifdef TELEM_TIMEOUT_EN
                            tcnt_q  <= 8'd0;
`endif
                        end
                    end
                end
                S_PRESENT: begin
                    if (vld_q && OUT_RDY) begin
                        vld_q   <= 1'b0;
                        ack_q   <= 4'b0001 << sel_q;
                        ptr_q   <= sel_q;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
`ifdef TELEM_TIMEOUT_EN
                    end else if (TICK && (tcnt_q == TO8 - 8'd1)) begin
                        vld_q   <= 1'b0;
                        ack_q   <= 4'b0001 << sel_q;
                        ptr_q   <= sel_q;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (TICK) begin
                        tcnt_q  <= tcnt_q + 8'd1;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign PH      = ph_q;
    assign SEL     = sel_q;
    assign LOAD    = load_q;
    assign ZERW    = zerw_q;
    assign BUSY    = busy_q;
    assign OUT_VLD = vld_q;
    assign OUT_CH  = och_q;
    assign OUT_BIT = obit_q;
    assign ACK     = ack_q;

endmodule
